// File: rtl/usb_tx_buffered.sv
// USB low/full-speed transmit engine fed by a {last,data} byte FIFO: SYNC, LSB-first data,
// bit stuffing, NRZI, EOP and inter-packet gap, with underrun abort and drop of the remainder.
module usb_tx_buffered #(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned CLKS_PER_BIT = 2,
    parameter int unsigned LS_DIVIDE    = 8,
    parameter int unsigned IFG_BITS     = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        low_speed,
    input  logic [7:0]                  wr_data,
    input  logic                        wr_last,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    output logic [1:0]                  d_o,
    output logic                        d_en,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        underrun
);
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned LS_CLKS = CLKS_PER_BIT * LS_DIVIDE;
    localparam int unsigned TW      = $clog2(LS_CLKS + 1);
    localparam int unsigned GW      = $clog2(IFG_BITS + 1);
    localparam logic [TW-1:0] FS_RELOAD  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] LS_RELOAD  = TW'(LS_CLKS - 1);
    localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StSync, StData, StEop, StGap} state_t;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, pkt_cnt_q;
    logic          drop_q, rdy_q;

    state_t        state_q;
    logic          ls_q;
    logic [TW-1:0] tmr_q;
    logic [7:0]    sh_q;
    logic [2:0]    bit_cnt_q, ones_q;
    logic          cur_last_q;
    logic [1:0]    eop_cnt_q;
    logic [GW-1:0] gap_cnt_q;

    logic [8:0]    head;
    logic          full, empty, tick, start_cond, launch;
    logic          byte_end, need_byte, pop, push, wr_fire, underrun_now;
    logic [1:0]    j_cur, j_new;
    logic [TW-1:0] reload_cur;

    always_comb begin
        head         = mem[rd_ptr_q];
        full         = count_q == FULL_LEVEL;
        empty        = count_q == '0;
        tick         = tmr_q == '0;
        j_cur        = ls_q ? 2'b01 : 2'b10;
        j_new        = low_speed ? 2'b01 : 2'b10;
        reload_cur   = ls_q ? LS_RELOAD : FS_RELOAD;
        start_cond   = (pkt_cnt_q != '0) || full;
        // The last gap bit hands straight over to SYNC so the gap is exactly IFG_BITS long.
        launch       = start_cond && ((state_q == StIdle) ||
                       (state_q == StGap && tick && gap_cnt_q == '0));
        byte_end     = (state_q == StSync || state_q == StData) && tick &&
                       (ones_q != 3'd6) && (bit_cnt_q == 3'd7);
        need_byte    = byte_end && (state_q == StSync || !cur_last_q);
        pop          = need_byte && !empty;
        underrun_now = need_byte && empty;
        wr_ready     = rdy_q && (drop_q || !full);
        wr_fire      = wr_valid && wr_ready;
        push         = wr_fire && !drop_q;
    end

    assign fifo_level = count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pkt_cnt_q <= '0;
            drop_q    <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q   <= count_q + (AW+1)'(push) - (AW+1)'(pop);
            pkt_cnt_q <= pkt_cnt_q + (AW+1)'(push && wr_last) - (AW+1)'(pop && head[8]);
            if (underrun_now) begin
                drop_q <= 1'b1;
            end else if (wr_fire && drop_q && wr_last) begin
                drop_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {wr_last, wr_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            d_o        <= 2'b10;
            d_en       <= 1'b0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
            ls_q       <= 1'b0;
            tmr_q      <= '0;
            sh_q       <= '0;
            bit_cnt_q  <= '0;
            ones_q     <= '0;
            cur_last_q <= 1'b0;
            eop_cnt_q  <= '0;
            gap_cnt_q  <= '0;
        end else begin
            underrun <= 1'b0;
            if (launch) begin
                // SYNC is shifted out as byte 0x80; its first bit is a 0, i.e. a K.
                state_q    <= StSync;
                ls_q       <= low_speed;
                tmr_q      <= low_speed ? LS_RELOAD : FS_RELOAD;
                d_o        <= ~j_new;
                d_en       <= 1'b1;
                busy       <= 1'b1;
                sh_q       <= 8'h80;
                bit_cnt_q  <= '0;
                ones_q     <= '0;
                cur_last_q <= 1'b0;
            end else if (state_q != StIdle) begin
                if (!tick) begin
                    tmr_q <= tmr_q - TW'(1);
                end else begin
                    tmr_q <= reload_cur;
                    case (state_q)
                        StSync, StData: begin
                            if (ones_q == 3'd6) begin
                                d_o    <= ~d_o;
                                ones_q <= '0;
                            end else if (bit_cnt_q != 3'd7) begin
                                sh_q      <= sh_q >> 1;
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                if (sh_q[1]) begin
                                    ones_q <= ones_q + 3'd1;
                                end else begin
                                    d_o    <= ~d_o;
                                    ones_q <= '0;
                                end
                            end else if (pop) begin
                                state_q    <= StData;
                                sh_q       <= head[7:0];
                                cur_last_q <= head[8];
                                bit_cnt_q  <= '0;
                                if (head[0]) begin
                                    ones_q <= ones_q + 3'd1;
                                end else begin
                                    d_o    <= ~d_o;
                                    ones_q <= '0;
                                end
                            end else begin
                                underrun  <= underrun_now;
                                state_q   <= StEop;
                                d_o       <= 2'b00;
                                eop_cnt_q <= '0;
                            end
                        end
                        StEop: begin
                            eop_cnt_q <= eop_cnt_q + 2'd1;
                            if (eop_cnt_q == 2'd1) begin
                                d_o <= j_cur;
                            end else if (eop_cnt_q == 2'd2) begin
                                state_q   <= StGap;
                                d_en      <= 1'b0;
                                busy      <= 1'b0;
                                gap_cnt_q <= GW'(IFG_BITS - 1);
                            end
                        end
                        StGap: begin
                            if (gap_cnt_q == '0) begin
                                state_q <= StIdle;
                            end else begin
                                gap_cnt_q <= gap_cnt_q - GW'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule
